// File: rtl/avalon_mm_arbiter.sv
// -----------------------------------------------------------------------------
// avalon_mm_arbiter
//
// Shares one Avalon-MM read/write agent between two hosts (typically host 0 =
// instruction fetch, host 1 = load/store unit). One command per cycle is
// forwarded to the agent with zero added latency. The grant is held across
// agent wait-states. The owner of every accepted read is remembered in a small
// FIFO so that each readdatavalid beat is returned to the host that issued it.
//
// Build option:
//   AVMM_ARB_ROUND_ROBIN_EN  defined   -> round-robin tie-break (the host that
//                                          was not granted last wins a tie)
//                            undefined -> fixed priority, host 0 wins every tie
//
// Parameters:
//   MAX_PENDING  outstanding reads tracked (owner FIFO depth), >= 1
//   ADDR_W       address width
//   DATA_W       data width (byteenable is DATA_W/8 wide)
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   host0_* / host1_*           upstream ports (agent side of each host)
//     address, byteenable, read, write, host_to_agent   (in)
//     waitrequest, readdatavalid, agent_to_host         (out)
//   agent_*                     downstream port towards the shared agent
//     address, byteenable, read, write, host_to_agent   (out)
//     waitrequest, readdatavalid, agent_to_host         (in)
// -----------------------------------------------------------------------------
module avalon_mm_arbiter #(
  parameter int MAX_PENDING = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int BE_W        = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,

  input  logic [ADDR_W-1:0] host0_address,
  input  logic [BE_W-1:0]   host0_byteenable,
  input  logic              host0_read,
  input  logic              host0_write,
  input  logic [DATA_W-1:0] host0_host_to_agent,
  output logic              host0_waitrequest,
  output logic              host0_readdatavalid,
  output logic [DATA_W-1:0] host0_agent_to_host,

  input  logic [ADDR_W-1:0] host1_address,
  input  logic [BE_W-1:0]   host1_byteenable,
  input  logic              host1_read,
  input  logic              host1_write,
  input  logic [DATA_W-1:0] host1_host_to_agent,
  output logic              host1_waitrequest,
  output logic              host1_readdatavalid,
  output logic [DATA_W-1:0] host1_agent_to_host,

  output logic [ADDR_W-1:0] agent_address,
  output logic [BE_W-1:0]   agent_byteenable,
  output logic              agent_read,
  output logic              agent_write,
  output logic [DATA_W-1:0] agent_host_to_agent,
  input  logic              agent_waitrequest,
  input  logic              agent_readdatavalid,
  input  logic [DATA_W-1:0] agent_agent_to_host
);

  localparam int PTR_W = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
  localparam int CNT_W = $clog2(MAX_PENDING + 1);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Request vectors, indexed by host number
  // ---------------------------------------------------------------------------
  logic [1:0] host_rd;
  logic [1:0] host_wr;
  logic [1:0] host_req;
  logic [1:0] host_wait;
  logic [1:0] host_rdv;

  assign host_rd  = {host1_read,  host0_read};
  assign host_wr  = {host1_write, host0_write};
  assign host_req = host_rd | host_wr;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t state_reg, state_next;
  logic   owner_reg, owner_next;   // host holding the lock while LOCKED

`ifdef AVMM_ARB_ROUND_ROBIN_EN
  logic   last_grant_reg;          // host whose command was accepted last
`endif

  // Owner FIFO: one bit per outstanding read
  logic             owner_mem [MAX_PENDING];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             fifo_empty;
  logic             fifo_full;
  logic             fifo_head;

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == CNT_W'(MAX_PENDING));
  assign fifo_head  = owner_mem[rd_ptr_reg];

  // ---------------------------------------------------------------------------
  // Winner selection
  // ---------------------------------------------------------------------------
  logic winner;

  always_comb begin
    winner = 1'b0;
    if (reset) begin
      winner = 1'b0;                     // datapath follows host 0 in reset
    end else if (state_reg == LOCKED) begin
      winner = owner_reg;
    end else if (host_req == 2'b11) begin
`ifdef AVMM_ARB_ROUND_ROBIN_EN
      winner = ~last_grant_reg;
`else
      winner = 1'b0;
`endif
    end else if (host_req[1]) begin
      winner = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Command path
  // ---------------------------------------------------------------------------
  logic win_rd;
  logic win_wr;
  logic pop;
  logic push;
  logic read_room;
  logic issue;
  logic accept;

  // read has precedence if a host illegally raises both strobes
  assign win_rd = host_rd[winner];
  assign win_wr = host_wr[winner] & ~win_rd;

  // A beat returning this cycle frees a slot, so a read can go out in the
  // same cycle the FIFO drops from full.
  assign pop       = agent_readdatavalid & ~fifo_empty & ~reset;
  assign read_room = ~fifo_full | pop;

  assign agent_read  = ~reset & win_rd & read_room;
  assign agent_write = ~reset & win_wr;

  assign issue  = agent_read | agent_write;
  assign accept = issue & ~agent_waitrequest;
  assign push   = accept & agent_read;

  assign agent_address       = winner ? host1_address       : host0_address;
  assign agent_byteenable    = winner ? host1_byteenable    : host0_byteenable;
  assign agent_host_to_agent = winner ? host1_host_to_agent : host0_host_to_agent;

  // ---------------------------------------------------------------------------
  // Per-host handshake and response routing
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_host
    // Only the host whose command is actually on the agent bus may see the
    // agent's waitrequest; everyone else (including a read held back by a
    // full FIFO) is stalled.
    assign host_wait[gi] = ~(issue & (winner == 1'(gi))) | agent_waitrequest;
    assign host_rdv[gi]  = pop & (fifo_head == 1'(gi));
  end

  assign host0_waitrequest   = host_wait[0];
  assign host1_waitrequest   = host_wait[1];
  assign host0_readdatavalid = host_rdv[0];
  assign host1_readdatavalid = host_rdv[1];
  assign host0_agent_to_host = agent_agent_to_host;
  assign host1_agent_to_host = agent_agent_to_host;

  // ---------------------------------------------------------------------------
  // Lock FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    case (state_reg)
      IDLE: begin
        if (issue && agent_waitrequest) begin
          state_next = LOCKED;
          owner_next = winner;
        end
      end
      LOCKED: begin
        // Leaving on a dropped request keeps a misbehaving host from
        // wedging the bus forever.
        if (accept || !host_req[owner_reg]) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      owner_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
    end
  end

`ifdef AVMM_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_reg <= 1'b1;            // host 0 wins the first tie
    end else if (accept) begin
      last_grant_reg <= winner;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Owner FIFO
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      owner_mem[wr_ptr_reg] <= winner;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= (wr_ptr_reg == PTR_W'(MAX_PENDING - 1)) ? '0 : wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= (rd_ptr_reg == PTR_W'(MAX_PENDING - 1)) ? '0 : rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

`ifndef SYNTHESIS
  // A response with nothing outstanding has no owner; it is dropped above.
  rdv_with_empty_fifo: assert property (
    @(posedge clk) disable iff (reset) !(agent_readdatavalid && fifo_empty)
  );
`endif

endmodule

// File: tb/tb_avalon_mm_arbiter.sv
module tb_avalon_mm_arbiter;

  localparam int MAXP = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] host0_address, host1_address, agent_address;
  logic [3:0]  host0_byteenable, host1_byteenable, agent_byteenable;
  logic        host0_read, host0_write, host1_read, host1_write;
  logic [31:0] host0_host_to_agent, host1_host_to_agent, agent_host_to_agent;
  logic        host0_waitrequest, host1_waitrequest;
  logic        host0_readdatavalid, host1_readdatavalid;
  logic [31:0] host0_agent_to_host, host1_agent_to_host;
  logic        agent_read, agent_write;
  logic        agent_waitrequest, agent_readdatavalid;
  logic [31:0] agent_agent_to_host;

  avalon_mm_arbiter #(.MAX_PENDING(MAXP), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .host0_address(host0_address), .host0_byteenable(host0_byteenable),
    .host0_read(host0_read), .host0_write(host0_write),
    .host0_host_to_agent(host0_host_to_agent), .host0_waitrequest(host0_waitrequest),
    .host0_readdatavalid(host0_readdatavalid), .host0_agent_to_host(host0_agent_to_host),
    .host1_address(host1_address), .host1_byteenable(host1_byteenable),
    .host1_read(host1_read), .host1_write(host1_write),
    .host1_host_to_agent(host1_host_to_agent), .host1_waitrequest(host1_waitrequest),
    .host1_readdatavalid(host1_readdatavalid), .host1_agent_to_host(host1_agent_to_host),
    .agent_address(agent_address), .agent_byteenable(agent_byteenable),
    .agent_read(agent_read), .agent_write(agent_write),
    .agent_host_to_agent(agent_host_to_agent), .agent_waitrequest(agent_waitrequest),
    .agent_readdatavalid(agent_readdatavalid), .agent_agent_to_host(agent_agent_to_host)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } cmd_t;
  typedef struct { int host; logic [31:0] data; } resp_t;
  typedef struct { logic [31:0] data; int due; } beat_t;

  cmd_t  hq [2][$];      // per-host command streams
  bit    presenting [2];
  resp_t sb [$];         // expected responses in return order
  beat_t aq [$];         // agent model: beats waiting to be returned
  int    pend [$];       // reference: owners of outstanding reads

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_due = 0;
  int rst_cycles = 0;
  int wait_pct = 0, lat_min = 1, lat_max = 1, forced_wait = 0;
  bit fixed_data = 0, rand_gap = 0;
  int lock_owner = -1, last_g = 1;
  int cnt_rdv [2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus driver: hosts and agent, 1 time unit after the rising edge
  // ---------------------------------------------------------------------------
  always @(posedge clk) begin
    #1;
    cyc++;
    reset = (rst_cycles > 0);
    if (rst_cycles > 0) rst_cycles--;
    if (reset) begin
      hq[0].delete();
      hq[1].delete();
      presenting[0] = 0;
      presenting[1] = 0;
      aq.delete();
      last_due = 0;
    end
    for (int i = 0; i < 2; i++)
      if (!presenting[i] && hq[i].size() > 0)
        presenting[i] = !rand_gap || ($urandom_range(0, 2) != 0);
    if (presenting[0]) begin
      host0_read = hq[0][0].rd;  host0_write = hq[0][0].wr;
      host0_address = hq[0][0].addr; host0_byteenable = hq[0][0].be;
      host0_host_to_agent = hq[0][0].wdata;
    end else begin
      host0_read = 0; host0_write = 0; host0_address = $urandom;
    end
    if (presenting[1]) begin
      host1_read = hq[1][0].rd;  host1_write = hq[1][0].wr;
      host1_address = hq[1][0].addr; host1_byteenable = hq[1][0].be;
      host1_host_to_agent = hq[1][0].wdata;
    end else begin
      host1_read = 0; host1_write = 0; host1_address = $urandom;
    end
    if (forced_wait > 0) begin
      agent_waitrequest = 1;
      forced_wait--;
    end else begin
      agent_waitrequest = ($urandom_range(0, 99) < wait_pct);
    end
    if (!reset && aq.size() > 0 && aq[0].due <= cyc) begin
      agent_readdatavalid = 1;
      agent_agent_to_host = aq[0].data;
      void'(aq.pop_front());
    end else begin
      agent_readdatavalid = 0;
      agent_agent_to_host = $urandom;
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model: arbitration rules applied to the current requests
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    bit rd [2];
    bit wr [2];
    bit rq [2];
    logic [31:0] h_addr [2];
    logic [31:0] h_wd [2];
    logic [3:0]  h_be [2];
    int win;
    bit is_rd, is_wr, pop, room, e_read, e_write, acc;
    logic e_wait0, e_wait1;
    logic [31:0] d;
    int due;
    rd[0] = host0_read;  wr[0] = host0_write;
    rd[1] = host1_read;  wr[1] = host1_write;
    h_addr[0] = host0_address; h_addr[1] = host1_address;
    h_wd[0] = host0_host_to_agent; h_wd[1] = host1_host_to_agent;
    h_be[0] = host0_byteenable; h_be[1] = host1_byteenable;
    for (int i = 0; i < 2; i++) rq[i] = rd[i] || wr[i];
    if (reset) begin
      chk("rst_agent_read", agent_read, 0);
      chk("rst_agent_write", agent_write, 0);
      chk("rst_wait0", host0_waitrequest, 1);
      chk("rst_wait1", host1_waitrequest, 1);
      chk("rst_rdv0", host0_readdatavalid, 0);
      chk("rst_rdv1", host1_readdatavalid, 0);
      lock_owner = -1;
      last_g = 1;
      pend.delete();
      sb.delete();
    end else begin
      if (lock_owner >= 0) win = lock_owner;
      else if (rq[0] && rq[1]) begin
`ifdef AVMM_ARB_ROUND_ROBIN_EN
        win = (last_g == 0) ? 1 : 0;
`else
        win = 0;
`endif
      end else if (rq[1]) win = 1;
      else win = 0;
      is_rd   = rd[win];
      is_wr   = wr[win] && !rd[win];
      pop     = agent_readdatavalid && pend.size() > 0;
      room    = (pend.size() < MAXP) || pop;
      e_read  = is_rd && room;
      e_write = is_wr;
      e_wait0 = (win == 0 && (e_read || e_write)) ? agent_waitrequest : 1'b1;
      e_wait1 = (win == 1 && (e_read || e_write)) ? agent_waitrequest : 1'b1;
      chk("agent_read", agent_read, e_read);
      chk("agent_write", agent_write, e_write);
      chk("wait0", host0_waitrequest, e_wait0);
      chk("wait1", host1_waitrequest, e_wait1);
      chk("rdv0", host0_readdatavalid, pop && pend[0] == 0);
      chk("rdv1", host1_readdatavalid, pop && pend[0] == 1);
      if (e_read || e_write) begin
        chk("agent_address", agent_address, h_addr[win]);
        chk("agent_byteenable", agent_byteenable, h_be[win]);
      end
      if (e_write) chk("agent_wdata", agent_host_to_agent, h_wd[win]);
      acc = (e_read || e_write) && !agent_waitrequest;
      if (pop) void'(pend.pop_front());
      if (acc) begin
        void'(hq[win].pop_front());
        presenting[win] = 0;
        last_g = win;
        if (e_read) begin
          d = fixed_data ? 32'hDEADBEEF : $urandom;
          due = cyc + $urandom_range(lat_min, lat_max);
          if (due < last_due) due = last_due;
          last_due = due;
          aq.push_back('{data: d, due: due});
          sb.push_back('{host: win, data: d});
          pend.push_back(win);
        end
      end
      if (lock_owner < 0) begin
        if ((e_read || e_write) && agent_waitrequest) lock_owner = win;
      end else if (acc || !rq[lock_owner]) begin
        lock_owner = -1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response monitor: pops the scoreboard whenever a host gets a beat
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    resp_t e;
    logic [31:0] got [2];
    bit rdv [2];
    rdv[0] = host0_readdatavalid; rdv[1] = host1_readdatavalid;
    got[0] = host0_agent_to_host; got[1] = host1_agent_to_host;
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        if (rdv[i]) begin
          cnt_rdv[i]++;
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_beat cyc=%0d host=%0d actual=1 required=0", cyc, i);
          end else begin
            e = sb.pop_front();
            chk("resp_host", i, e.host);
            chk("resp_data", got[i], e.data);
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  task automatic push_cmd(input int h, input bit rd, input bit wr);
    cmd_t c;
    c.rd = rd;
    c.wr = wr;
    c.addr = (32'(h) << 16) | 32'($urandom_range(0, 65535));
    c.wdata = $urandom;
    c.be = 4'($urandom_range(1, 15));
    hq[h].push_back(c);
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((hq[0].size() > 0 || hq[1].size() > 0 || aq.size() > 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    total++;
    if (n >= budget) begin
      bad++;
      $display("FAIL %s_timeout cyc=%0d actual=%0d required<%0d", name, cyc, n, budget);
    end
  endtask

  initial begin
    int r;
    reset = 1; host0_read = 0; host0_write = 0; host1_read = 0; host1_write = 0;
    host0_address = 0; host1_address = 0; host0_byteenable = 0; host1_byteenable = 0;
    host0_host_to_agent = 0; host1_host_to_agent = 0;
    agent_waitrequest = 0; agent_readdatavalid = 0; agent_agent_to_host = 0;
    cnt_rdv[0] = 0; cnt_rdv[1] = 0;
    rst_cycles = 3;
    repeat (5) @(negedge clk);

    // single read from host 0, fixed data, latency 2
    lat_min = 2; lat_max = 2; fixed_data = 1;
    cnt_rdv[0] = 0; cnt_rdv[1] = 0;
    push_cmd(0, 1, 0);
    drain("single_read", 50);
    chk("single_rdv0_count", cnt_rdv[0], 1);
    chk("single_rdv1_count", cnt_rdv[1], 0);
    fixed_data = 0;

    // both hosts reading back-to-back, agent never waits
    lat_min = 1; lat_max = 3;
    for (int k = 0; k < 8; k++) begin
      push_cmd(0, 1, 0);
      push_cmd(1, 1, 0);
    end
    drain("contention", 200);

    // host 1 write locked by 3 agent wait-states, host 0 arrives behind it
    forced_wait = 3;
    push_cmd(1, 0, 1);
    @(negedge clk);
    push_cmd(0, 1, 0);
    drain("locked_write", 50);

    // fill the owner FIFO, then a write from the other host
    lat_min = 12; lat_max = 12;
    for (int k = 0; k < 5; k++) push_cmd(0, 1, 0);
    push_cmd(1, 0, 1);
    drain("fifo_full", 200);

    // randomized traffic with wait-states and gaps
    wait_pct = 25; lat_min = 1; lat_max = 6; rand_gap = 1;
    for (int k = 0; k < 150; k++) begin
      for (int h = 0; h < 2; h++) begin
        r = $urandom_range(0, 99);
        push_cmd(h, (r < 50) || (r >= 95), r >= 50);
      end
    end
    drain("random", 4000);

    // reset with reads outstanding, then a tie
    wait_pct = 0; rand_gap = 0; lat_min = 8; lat_max = 8;
    push_cmd(0, 1, 0); push_cmd(1, 1, 0);
    repeat (4) @(negedge clk);
    rst_cycles = 2;
    repeat (4) @(negedge clk);
    lat_min = 1; lat_max = 2;
    push_cmd(0, 1, 0); push_cmd(1, 1, 0);
    push_cmd(0, 0, 1); push_cmd(1, 0, 1);
    drain("post_reset", 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
